// File: rtl/ibex_irq_latch.sv
// Interrupt front-end: synchronises raw interrupt lines, latches pending state
// (level or rising-edge per line) and picks the highest-priority enabled cause.
module ibex_irq_latch #(
    parameter int          SyncStages   = 2,
    parameter logic [14:0] FastEdgeMask = 15'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic        irq_nm_i,
    input  logic [17:0] irq_en_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_ack_id_i,
    output logic [17:0] irqs_o,
    output logic        irq_nm_o,
    output logic        irq_valid_o,
    output logic [4:0]  irq_id_o
);

    localparam int NumLines = 19;

    // Line index matches the irqs_t layout with NMI stacked on top:
    // [14:0] fast, 15 external, 16 timer, 17 software, 18 NMI.
    localparam logic [NumLines-1:0] EdgeMask = {1'b1, 3'b000, FastEdgeMask};

    logic [NumLines-1:0] raw_lines;
    logic [NumLines-1:0] sync_reg [SyncStages];
    logic [NumLines-1:0] sync_s;
    logic [NumLines-1:0] hist_reg;
    logic [NumLines-1:0] edge_det;
    logic [NumLines-1:0] pending_reg;
    logic [NumLines-1:0] pending_next;
    logic [NumLines-1:0] active;
    logic [4:0]          irq_id_next;

    assign raw_lines = {irq_nm_i, irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
    assign sync_s    = sync_reg[SyncStages-1];
    assign edge_det  = sync_s & ~hist_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < SyncStages; k++) begin
                sync_reg[k] <= '0;
            end
            hist_reg    <= '0;
            pending_reg <= '0;
        end else begin
            sync_reg[0] <= raw_lines;
            for (int k = 1; k < SyncStages; k++) begin
                sync_reg[k] <= sync_reg[k-1];
            end
            hist_reg    <= sync_s;
            pending_reg <= pending_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NumLines; gi++) begin : g_line
            if (EdgeMask[gi]) begin : g_edge
                localparam logic [4:0] LineId = (gi == NumLines - 1) ? 5'd31 : 5'(16 + gi);
                logic ack_hit;
                assign ack_hit = irq_ack_i && (irq_ack_id_i == LineId);
                // A fresh edge in the ack cycle must not be lost, so set wins.
                assign pending_next[gi] = (pending_reg[gi] & ~ack_hit) | edge_det[gi];
            end else begin : g_level
                assign pending_next[gi] = sync_s[gi];
            end
        end
    endgenerate

    assign active = pending_reg & {1'b1, irq_en_i};

    always_comb begin
        irq_id_next = 5'd0;
        if (active[18]) begin
            irq_id_next = 5'd31;
        end else if (|active[14:0]) begin
            // Walk downwards so the lowest fast index is the one left standing.
            for (int i = 14; i >= 0; i--) begin
                if (active[i]) begin
                    irq_id_next = 5'(16 + i);
                end
            end
        end else if (active[15]) begin
            irq_id_next = 5'd11;
        end else if (active[17]) begin
            irq_id_next = 5'd3;
        end else if (active[16]) begin
            irq_id_next = 5'd7;
        end
    end

    assign irqs_o      = pending_reg[17:0];
    assign irq_nm_o    = pending_reg[18];
    assign irq_valid_o = |active;
    assign irq_id_o    = irq_id_next;

endmodule

// File: tb/tb_ibex_irq_latch.sv
// Self-checking bench for ibex_irq_latch: directed scenarios plus random
// traffic compared against a delay-queue behavioural model.
module tb_ibex_irq_latch;

    localparam int          SYNC      = 2;
    localparam logic [14:0] FAST_EDGE = 15'h0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sw = 1'b0, tmr = 1'b0, ext = 1'b0, nm = 1'b0;
    logic [14:0] fast = '0;
    logic [17:0] en = '0;
    logic        ack = 1'b0;
    logic [4:0]  ack_id = '0;
    logic [17:0] irqs;
    logic        irq_nm, irq_valid;
    logic [4:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ibex_irq_latch #(
        .SyncStages  (SYNC),
        .FastEdgeMask(FAST_EDGE)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .irq_software_i(sw),
        .irq_timer_i   (tmr),
        .irq_external_i(ext),
        .irq_fast_i    (fast),
        .irq_nm_i      (nm),
        .irq_en_i      (en),
        .irq_ack_i     (ack),
        .irq_ack_id_i  (ack_id),
        .irqs_o        (irqs),
        .irq_nm_o      (irq_nm),
        .irq_valid_o   (irq_valid),
        .irq_id_o      (irq_id)
    );

    // ---------------- behavioural model ----------------
    // Bit b of a 19-bit line vector: 0..14 fast, 15 ext, 16 timer, 17 sw, 18 nmi.
    logic [18:0] delay_q [$];
    logic [18:0] m_prev;
    logic [18:0] m_pend;

    function automatic logic [4:0] cause_of(int b);
        if (b == 18) return 5'd31;
        if (b < 15)  return 5'(16 + b);
        if (b == 15) return 5'd11;
        if (b == 17) return 5'd3;
        return 5'd7;
    endfunction

    function automatic bit is_edge_line(int b);
        if (b == 18) return 1'b1;
        if (b < 15)  return FAST_EDGE[b];
        return 1'b0;
    endfunction

    function automatic logic [4:0] exp_id(logic [18:0] pend, logic [17:0] mask);
        int order [19] = '{18, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 16};
        logic [18:0] act;
        act = pend & {1'b1, mask};
        foreach (order[k]) begin
            if (act[order[k]]) return cause_of(order[k]);
        end
        return 5'd0;
    endfunction

    function automatic logic exp_valid(logic [18:0] pend, logic [17:0] mask);
        return |(pend & {1'b1, mask});
    endfunction

    always @(posedge clk) begin
        logic [18:0] s;
        if (!rst_n) begin
            delay_q = {};
            for (int k = 0; k < SYNC; k++) delay_q.push_back(19'd0);
            m_prev = '0;
            m_pend = '0;
        end else begin
            // Value seen by the pending logic was sampled SYNC edges ago.
            s = delay_q[0];
            for (int b = 0; b < 19; b++) begin
                if (!is_edge_line(b)) begin
                    m_pend[b] = s[b];
                end else if (s[b] && !m_prev[b]) begin
                    m_pend[b] = 1'b1;
                end else if (ack && ack_id == cause_of(b)) begin
                    m_pend[b] = 1'b0;
                end
            end
            m_prev = s;
            void'(delay_q.pop_front());
            delay_q.push_back({nm, sw, tmr, ext, fast});
        end
    end

    // ---------------- scenarios ----------------
    task automatic do_reset();
        {sw, tmr, ext, nm} = '0;
        fast = '0;
        ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        {sw, tmr, ext, nm} = '1;
        fast = '1;
        en = '1;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (irqs !== 18'h0) begin n_fail++; $display("FAIL reset_irqs cyc%0d got %h exp 0", c, irqs); end
            n_checks++; if (irq_nm !== 1'b0) begin n_fail++; $display("FAIL reset_nm cyc%0d got %b exp 0", c, irq_nm); end
            n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d got %b exp 0", c, irq_valid); end
            n_checks++; if (irq_id !== 5'd0) begin n_fail++; $display("FAIL reset_id cyc%0d got %0d exp 0", c, irq_id); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (irqs !== 18'h0) begin n_fail++; $display("FAIL reset_latency_early got %h exp 0", irqs); end
        @(negedge clk);
        n_checks++; if (irqs !== 18'h3FFFF) begin n_fail++; $display("FAIL reset_release_irqs got %h exp 3ffff", irqs); end
        n_checks++; if (irq_nm !== 1'b1) begin n_fail++; $display("FAIL reset_release_nm got %b exp 1", irq_nm); end
        $display("test_reset done");
    endtask

    task automatic test_level_timer();
        do_reset();
        en = 18'h10000;
        tmr = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL timer_early_valid got %b exp 0", irq_valid); end
        @(negedge clk);
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL timer_valid got %b exp 1", irq_valid); end
        n_checks++; if (irq_id !== 5'd7) begin n_fail++; $display("FAIL timer_id got %0d exp 7", irq_id); end
        tmr = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL timer_hold_valid got %b exp 1", irq_valid); end
        @(negedge clk);
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL timer_clear_valid got %b exp 0", irq_valid); end
        n_checks++; if (irq_id !== 5'd0) begin n_fail++; $display("FAIL timer_clear_id got %0d exp 0", irq_id); end
        $display("test_level_timer done");
    endtask

    task automatic test_edge_fast4();
        do_reset();
        en = 18'h00010;
        fast = 15'h0010;
        repeat (2) @(negedge clk);
        fast = '0;
        repeat (6) @(negedge clk);
        n_checks++; if (irqs !== 18'h00010) begin n_fail++; $display("FAIL fast4_latched got %h exp 00010", irqs); end
        n_checks++; if (irq_id !== 5'd20) begin n_fail++; $display("FAIL fast4_id got %0d exp 20", irq_id); end
        ack = 1'b1; ack_id = 5'd21;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (irqs !== 18'h00010) begin n_fail++; $display("FAIL fast4_wrong_ack got %h exp 00010", irqs); end
        ack = 1'b1; ack_id = 5'd20;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (irqs !== 18'h0) begin n_fail++; $display("FAIL fast4_ack_clear got %h exp 0", irqs); end
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL fast4_ack_valid got %b exp 0", irq_valid); end
        $display("test_edge_fast4 done");
    endtask

    task automatic test_priority();
        do_reset();
        fast = 15'h0008; ext = 1'b1; sw = 1'b1;
        en = '1;
        repeat (4) @(negedge clk);
        n_checks++; if (irq_id !== 5'd19) begin n_fail++; $display("FAIL prio_fast3 got %0d exp 19", irq_id); end
        n_checks++; if (irqs !== 18'h28008) begin n_fail++; $display("FAIL prio_irqs got %h exp 28008", irqs); end
        en[3] = 1'b0;
        #1;
        n_checks++; if (irq_id !== 5'd11) begin n_fail++; $display("FAIL prio_ext got %0d exp 11", irq_id); end
        en[15] = 1'b0;
        #1;
        n_checks++; if (irq_id !== 5'd3) begin n_fail++; $display("FAIL prio_sw got %0d exp 3", irq_id); end
        en = '0;
        #1;
        n_checks++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL prio_masked_valid got %b exp 0", irq_valid); end
        nm = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (irq_id !== 5'd31) begin n_fail++; $display("FAIL prio_nmi got %0d exp 31", irq_id); end
        n_checks++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL prio_nmi_valid got %b exp 1", irq_valid); end
        n_checks++; if (irqs !== 18'h28008) begin n_fail++; $display("FAIL prio_mask_keeps_pending got %h exp 28008", irqs); end
        $display("test_priority done");
    endtask

    task automatic test_set_and_ack();
        nm = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (irq_nm !== 1'b1) begin n_fail++; $display("FAIL nmi_stays_latched got %b exp 1", irq_nm); end
        nm = 1'b1;
        repeat (2) @(negedge clk);
        ack = 1'b1; ack_id = 5'd31;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (irq_nm !== 1'b1) begin n_fail++; $display("FAIL nmi_set_wins got %b exp 1", irq_nm); end
        ack = 1'b1; ack_id = 5'd31;
        @(negedge clk);
        ack = 1'b0;
        n_checks++; if (irq_nm !== 1'b0) begin n_fail++; $display("FAIL nmi_ack_clear got %b exp 0", irq_nm); end
        repeat (4) @(negedge clk);
        n_checks++; if (irq_nm !== 1'b0) begin n_fail++; $display("FAIL nmi_held_no_relatch got %b exp 0", irq_nm); end
        $display("test_set_and_ack done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        en = '0;
        fast = 15'h0010;
        repeat (2) @(negedge clk);
        fast = '0;
        repeat (4) @(negedge clk);
        n_checks++; if (irqs !== 18'h00010) begin n_fail++; $display("FAIL midrst_latched got %h exp 00010", irqs); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (irqs !== 18'h0) begin n_fail++; $display("FAIL midrst_cleared got %h exp 0", irqs); end
        repeat (5) @(negedge clk);
        n_checks++; if (irqs !== 18'h0) begin n_fail++; $display("FAIL midrst_no_relatch got %h exp 0", irqs); end
        $display("test_mid_reset done");
    endtask

    task automatic test_random();
        do_reset();
        en = 18'($urandom);
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(3) == 0) fast ^= 15'(1 << $urandom_range(14));
            if ($urandom_range(7) == 0) sw  = ~sw;
            if ($urandom_range(7) == 0) tmr = ~tmr;
            if ($urandom_range(7) == 0) ext = ~ext;
            if ($urandom_range(5) == 0) nm  = ~nm;
            if ($urandom_range(15) == 0) en = 18'($urandom);
            ack = ($urandom_range(2) == 0);
            ack_id = ($urandom_range(3) == 0) ? 5'($urandom) : 5'(16 + $urandom_range(15));
            rst_n = ($urandom_range(149) != 0);
            @(negedge clk);
            n_checks++; if (irqs !== m_pend[17:0]) begin n_fail++; $display("FAIL rand_irqs t%0d got %h exp %h", t, irqs, m_pend[17:0]); end
            n_checks++; if (irq_nm !== m_pend[18]) begin n_fail++; $display("FAIL rand_nm t%0d got %b exp %b", t, irq_nm, m_pend[18]); end
            n_checks++; if (irq_valid !== exp_valid(m_pend, en)) begin n_fail++; $display("FAIL rand_valid t%0d got %b exp %b", t, irq_valid, exp_valid(m_pend, en)); end
            n_checks++; if (irq_id !== exp_id(m_pend, en)) begin n_fail++; $display("FAIL rand_id t%0d got %0d exp %0d", t, irq_id, exp_id(m_pend, en)); end
        end
        ack = 1'b0;
        rst_n = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_level_timer();
        test_edge_fast4();
        test_priority();
        test_set_and_ack();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
